// File: rtl/ncpu32k_immu.sv
`timescale 1ns/1ps
// ncpu32k_immu -- instruction MMU sitting between the fetch unit and the icache.
//
// A fetch command is accepted into a one-deep stage. While it sits there, the TLB
// entry selected by the virtual page number has already been read. The stage then
// presents a physical address (translated or bypassed) to the icache. A flush
// request kills the pending command for one cycle so a redirect can be accepted at
// once. Instruction data flows straight back from the icache to the fetch unit.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ibus_cmd_*            fetch command in (valid/ready/addr)
//   ibus_valid/ready/dout instruction out (pass-through of icache data)
//   ibus_flush_req/ack    flush handshake
//   ibus_out_id(_nxt)     PC of current instruction / last accepted command
//   icache_cmd_*          physical command out to icache
//   icache_valid/ready/dout icache data in
//   exp_imm_*             TLB miss / page fault exceptions
//   msr_psr_imme/rm       IMMU enable, root mode
//   msr_immid             IMMU ID (TLB size)
//   msr_imm_tlbl/tlbh*    MSR access to the TLB RAMs (read-first)
module ncpu32k_immu #(
  parameter int          TLB_NSETS_LOG2 = 7,
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ibus_cmd_valid,
  output logic                      ibus_cmd_ready,
  input  logic [31:0]               ibus_cmd_addr,
  output logic                      ibus_valid,
  input  logic                      ibus_ready,
  output logic [31:0]               ibus_dout,
  input  logic                      ibus_flush_req,
  output logic                      ibus_flush_ack,
  output logic [31:0]               ibus_out_id,
  output logic [31:0]               ibus_out_id_nxt,
  output logic                      icache_cmd_valid,
  input  logic                      icache_cmd_ready,
  output logic [31:0]               icache_cmd_addr,
  input  logic                      icache_valid,
  output logic                      icache_ready,
  input  logic [31:0]               icache_dout,
  output logic                      exp_imm_tlb_miss,
  output logic                      exp_imm_page_fault,
  input  logic                      msr_psr_imme,
  input  logic                      msr_psr_rm,
  output logic [31:0]               msr_immid,
  output logic [31:0]               msr_imm_tlbl,
  input  logic [TLB_NSETS_LOG2-1:0] msr_imm_tlbl_idx,
  input  logic [31:0]               msr_imm_tlbl_nxt,
  input  logic                      msr_imm_tlbl_we,
  output logic [31:0]               msr_imm_tlbh,
  input  logic [TLB_NSETS_LOG2-1:0] msr_imm_tlbh_idx,
  input  logic [31:0]               msr_imm_tlbh_nxt,
  input  logic                      msr_imm_tlbh_we
);

  localparam int          NSets       = 2 ** TLB_NSETS_LOG2;
  localparam logic [2:0]  ImmIdLo     = 3'(TLB_NSETS_LOG2);
  localparam logic [31:0] ResetIdNext = RESET_VECTOR - 32'd4;

  // Command stage
  logic        r_cmd_vld;
  logic        r_fs;
  logic        w_flush_strobe;
  logic        w_accept;
  logic        w_icache_hs;

  // Registered command attributes
  logic        r_imme;
  logic        r_rm;
  logic [12:0] r_offset;
  logic [18:0] r_vpn;
  logic [31:0] r_bypass_addr;

  logic [31:0] r_out_id;
  logic [31:0] r_out_id_nxt;

  // TLB storage and read registers (port A: lookup, port B: MSR)
  logic [31:0] r_tlbl_mem [NSets];
  logic [31:0] r_tlbh_mem [NSets];
  logic [31:0] r_tlbl_a;
  logic [31:0] r_tlbh_a;
  logic [31:0] r_tlbl_b;
  logic [31:0] r_tlbh_b;
  logic [TLB_NSETS_LOG2-1:0] w_tlb_a_idx;

  // Decoded TLB entry
  logic        w_tlb_v;
  logic [18:0] w_tlb_vpn;
  logic        w_tlb_ux;
  logic        w_tlb_rx;
  logic [18:0] w_tlb_ppn;
  logic        w_miss;
  logic        w_denied;
  logic        w_pf;

  logic        r_exp_miss;
  logic        r_exp_pf;

  // A flush kills the pending command only once; r_fs remembers that the flush
  // was already seen when the icache consumed a command.
  assign w_flush_strobe = ibus_flush_req & ~r_fs;
  assign ibus_cmd_ready = ~r_cmd_vld | icache_cmd_ready | w_flush_strobe;
  assign w_accept       = ibus_cmd_valid & ibus_cmd_ready;
  assign icache_cmd_valid = r_cmd_vld & ~w_flush_strobe;
  assign ibus_flush_ack   = w_accept & ~w_flush_strobe;
  assign w_icache_hs      = icache_cmd_valid & icache_cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_vld <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd_vld <= 1'b1;
      end else if (icache_cmd_ready | w_flush_strobe) begin
        r_cmd_vld <= 1'b0;
      end
      if (r_cmd_vld & icache_cmd_ready) begin
        r_fs <= ibus_flush_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imme        <= 1'b0;
      r_rm          <= 1'b0;
      r_offset      <= '0;
      r_vpn         <= '0;
      r_bypass_addr <= '0;
      r_out_id_nxt  <= ResetIdNext;
    end else if (w_accept) begin
      r_imme        <= msr_psr_imme;
      r_rm          <= msr_psr_rm;
      r_offset      <= ibus_cmd_addr[12:0];
      r_vpn         <= ibus_cmd_addr[31:13];
      r_bypass_addr <= ibus_cmd_addr;
      r_out_id_nxt  <= ibus_cmd_addr;
    end
  end

  // On a flush the redirect target is the PC of the instruction being delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_id <= RESET_VECTOR;
    end else if (ibus_valid & ibus_ready) begin
      r_out_id <= ibus_flush_req ? ibus_cmd_addr : r_out_id_nxt;
    end
  end

  assign ibus_out_id     = r_out_id;
  assign ibus_out_id_nxt = r_out_id_nxt;

  // Data path is purely combinational
  assign ibus_valid   = icache_valid;
  assign icache_ready = ibus_ready;
  assign ibus_dout    = icache_dout;

  assign msr_immid = {29'b0, ImmIdLo};

  assign w_tlb_a_idx = ibus_cmd_addr[13 +: TLB_NSETS_LOG2];

  // TLBL RAM: port A lookup on accept, port B MSR read-first/write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSets; i++) begin
        r_tlbl_mem[i] <= '0;
      end
      r_tlbl_a <= '0;
      r_tlbl_b <= '0;
    end else begin
      if (w_accept) begin
        r_tlbl_a <= r_tlbl_mem[w_tlb_a_idx];
      end
      r_tlbl_b <= r_tlbl_mem[msr_imm_tlbl_idx];
      if (msr_imm_tlbl_we) begin
        r_tlbl_mem[msr_imm_tlbl_idx] <= msr_imm_tlbl_nxt;
      end
    end
  end

  // TLBH RAM: same organisation as TLBL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSets; i++) begin
        r_tlbh_mem[i] <= '0;
      end
      r_tlbh_a <= '0;
      r_tlbh_b <= '0;
    end else begin
      if (w_accept) begin
        r_tlbh_a <= r_tlbh_mem[w_tlb_a_idx];
      end
      r_tlbh_b <= r_tlbh_mem[msr_imm_tlbh_idx];
      if (msr_imm_tlbh_we) begin
        r_tlbh_mem[msr_imm_tlbh_idx] <= msr_imm_tlbh_nxt;
      end
    end
  end

  assign msr_imm_tlbl = r_tlbl_b;
  assign msr_imm_tlbh = r_tlbh_b;

  assign w_tlb_v   = r_tlbl_a[0];
  assign w_tlb_vpn = r_tlbl_a[31:13];
  assign w_tlb_ux  = r_tlbh_a[3];
  assign w_tlb_rx  = r_tlbh_a[4];
  assign w_tlb_ppn = r_tlbh_a[31:13];

  // P, S and reserved entry bits carry no meaning for instruction fetch
  logic w_unused_tlb_bits;
  assign w_unused_tlb_bits = ^{r_tlbl_a[12:1], r_tlbh_a[12:5], r_tlbh_a[2:0]};

  assign w_miss   = r_imme & ~(w_tlb_v & (w_tlb_vpn == r_vpn));
  assign w_denied = r_rm ? ~w_tlb_rx : ~w_tlb_ux;
  assign w_pf     = r_imme & w_denied & ~w_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_miss <= 1'b0;
      r_exp_pf   <= 1'b0;
    end else if (w_icache_hs) begin
      r_exp_miss <= w_miss;
      r_exp_pf   <= w_pf;
    end
  end

  assign exp_imm_tlb_miss   = r_exp_miss;
  assign exp_imm_page_fault = r_exp_pf;

  assign icache_cmd_addr = r_imme ? {w_tlb_ppn, r_offset} : r_bypass_addr;

endmodule

// File: tb/tb_ncpu32k_immu.sv
`timescale 1ns/1ps
module tb_ncpu32k_immu;

  localparam int          N     = 4;
  localparam int          Depth = 16;
  localparam logic [31:0] RV    = 32'h0000_1000;

  logic          clk;
  logic          rst_n;
  logic          ibus_cmd_valid;
  logic          ibus_cmd_ready;
  logic [31:0]   ibus_cmd_addr;
  logic          ibus_valid;
  logic          ibus_ready;
  logic [31:0]   ibus_dout;
  logic          ibus_flush_req;
  logic          ibus_flush_ack;
  logic [31:0]   ibus_out_id;
  logic [31:0]   ibus_out_id_nxt;
  logic          icache_cmd_valid;
  logic          icache_cmd_ready;
  logic [31:0]   icache_cmd_addr;
  logic          icache_valid;
  logic          icache_ready;
  logic [31:0]   icache_dout;
  logic          exp_imm_tlb_miss;
  logic          exp_imm_page_fault;
  logic          msr_psr_imme;
  logic          msr_psr_rm;
  logic [31:0]   msr_immid;
  logic [31:0]   msr_imm_tlbl;
  logic [N-1:0]  msr_imm_tlbl_idx;
  logic [31:0]   msr_imm_tlbl_nxt;
  logic          msr_imm_tlbl_we;
  logic [31:0]   msr_imm_tlbh;
  logic [N-1:0]  msr_imm_tlbh_idx;
  logic [31:0]   msr_imm_tlbh_nxt;
  logic          msr_imm_tlbh_we;

  ncpu32k_immu #(
    .TLB_NSETS_LOG2 (N),
    .RESET_VECTOR   (RV)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ibus_cmd_valid     (ibus_cmd_valid),
    .ibus_cmd_ready     (ibus_cmd_ready),
    .ibus_cmd_addr      (ibus_cmd_addr),
    .ibus_valid         (ibus_valid),
    .ibus_ready         (ibus_ready),
    .ibus_dout          (ibus_dout),
    .ibus_flush_req     (ibus_flush_req),
    .ibus_flush_ack     (ibus_flush_ack),
    .ibus_out_id        (ibus_out_id),
    .ibus_out_id_nxt    (ibus_out_id_nxt),
    .icache_cmd_valid   (icache_cmd_valid),
    .icache_cmd_ready   (icache_cmd_ready),
    .icache_cmd_addr    (icache_cmd_addr),
    .icache_valid       (icache_valid),
    .icache_ready       (icache_ready),
    .icache_dout        (icache_dout),
    .exp_imm_tlb_miss   (exp_imm_tlb_miss),
    .exp_imm_page_fault (exp_imm_page_fault),
    .msr_psr_imme       (msr_psr_imme),
    .msr_psr_rm         (msr_psr_rm),
    .msr_immid          (msr_immid),
    .msr_imm_tlbl       (msr_imm_tlbl),
    .msr_imm_tlbl_idx   (msr_imm_tlbl_idx),
    .msr_imm_tlbl_nxt   (msr_imm_tlbl_nxt),
    .msr_imm_tlbl_we    (msr_imm_tlbl_we),
    .msr_imm_tlbh       (msr_imm_tlbh),
    .msr_imm_tlbh_idx   (msr_imm_tlbh_idx),
    .msr_imm_tlbh_nxt   (msr_imm_tlbh_nxt),
    .msr_imm_tlbh_we    (msr_imm_tlbh_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference copy of the TLB contents
  logic [31:0] ml [Depth];
  logic [31:0] mh [Depth];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Translation rules computed directly from the entry fields
  task automatic model_fetch(input logic [31:0] addr, input logic imme, input logic rm,
                             output logic [31:0] ea, output logic miss, output logic pf);
    int unsigned vpn, idx, l, h;
    bit hit, allowed;
    vpn = addr / 8192;
    idx = vpn % Depth;
    l = ml[idx];
    h = mh[idx];
    hit = (l % 2 == 1) && (l / 8192 == vpn);
    allowed = rm ? ((h / 16) % 2 == 1) : ((h / 8) % 2 == 1);
    miss = imme && !hit;
    pf = imme && hit && !allowed;
    ea = imme ? ((h / 8192) * 8192 + addr % 8192) : addr;
  endtask

  task automatic msr_wr(input int idx, input logic [31:0] l, input logic [31:0] h);
    msr_imm_tlbl_idx = N'(idx);
    msr_imm_tlbh_idx = N'(idx);
    msr_imm_tlbl_nxt = l;
    msr_imm_tlbh_nxt = h;
    msr_imm_tlbl_we  = 1'b1;
    msr_imm_tlbh_we  = 1'b1;
    tick();
    msr_imm_tlbl_we  = 1'b0;
    msr_imm_tlbh_we  = 1'b0;
    ml[idx] = l;
    mh[idx] = h;
  endtask

  // One command through the stage with the icache always ready
  task automatic fetch(input string tag, input logic [31:0] addr, input logic imme,
                       input logic rm);
    logic [31:0] ea;
    logic miss, pf;
    model_fetch(addr, imme, rm, ea, miss, pf);
    ibus_cmd_valid = 1'b1;
    ibus_cmd_addr  = addr;
    msr_psr_imme   = imme;
    msr_psr_rm     = rm;
    #1;
    check({tag, " cmd_ready"}, {31'b0, ibus_cmd_ready}, 32'd1);
    check({tag, " flush_ack"}, {31'b0, ibus_flush_ack}, 32'd1);
    tick();
    ibus_cmd_valid = 1'b0;
    check({tag, " icache_cmd_valid"}, {31'b0, icache_cmd_valid}, 32'd1);
    check({tag, " icache_cmd_addr"}, icache_cmd_addr, ea);
    check({tag, " out_id_nxt"}, ibus_out_id_nxt, addr);
    tick();
    check({tag, " tlb_miss"}, {31'b0, exp_imm_tlb_miss}, {31'b0, miss});
    check({tag, " page_fault"}, {31'b0, exp_imm_page_fault}, {31'b0, pf});
    check({tag, " idle"}, {31'b0, icache_cmd_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] old, addr, l, h, d;
    int idx;
    for (int i = 0; i < Depth; i++) begin
      ml[i] = '0;
      mh[i] = '0;
    end
    rst_n = 1'b0;
    ibus_cmd_valid = 1'b0; ibus_cmd_addr = '0; ibus_ready = 1'b0; ibus_flush_req = 1'b0;
    icache_cmd_ready = 1'b0; icache_valid = 1'b0; icache_dout = '0;
    msr_psr_imme = 1'b0; msr_psr_rm = 1'b0;
    msr_imm_tlbl_idx = '0; msr_imm_tlbl_nxt = '0; msr_imm_tlbl_we = 1'b0;
    msr_imm_tlbh_idx = '0; msr_imm_tlbh_nxt = '0; msr_imm_tlbh_we = 1'b0;

    // Reset state
    #12;
    check("rst icache_cmd_valid", {31'b0, icache_cmd_valid}, 32'd0);
    check("rst tlb_miss", {31'b0, exp_imm_tlb_miss}, 32'd0);
    check("rst page_fault", {31'b0, exp_imm_page_fault}, 32'd0);
    check("rst out_id", ibus_out_id, RV);
    check("rst out_id_nxt", ibus_out_id_nxt, RV - 32'd4);
    check("rst cmd_ready", {31'b0, ibus_cmd_ready}, 32'd1);
    check("immid", msr_immid, 32'd4);
    #11;
    rst_n = 1'b1;
    tick();
    check("rst tlbl rd", msr_imm_tlbl, 32'd0);
    check("rst tlbh rd", msr_imm_tlbh, 32'd0);

    // Bypass fetch, then deliver its instruction
    icache_cmd_ready = 1'b1;
    fetch("bypass", 32'h0000_2004, 1'b0, 1'b0);
    d = $urandom;
    icache_valid = 1'b1; ibus_ready = 1'b1; icache_dout = d;
    #1;
    check("pass ibus_valid", {31'b0, ibus_valid}, 32'd1);
    check("pass icache_ready", {31'b0, icache_ready}, 32'd1);
    check("pass dout", ibus_dout, d);
    tick();
    icache_valid = 1'b0; ibus_ready = 1'b0;
    check("data out_id", ibus_out_id, 32'h0000_2004);

    // Translation hit, miss, permission
    msr_wr(1, 32'h0000_2001, 32'h0000_6018);
    fetch("hit", 32'h0000_2010, 1'b1, 1'b1);
    msr_wr(1, 32'h0000_0000, 32'h0000_6018);
    fetch("miss", 32'h0000_2010, 1'b1, 1'b1);
    msr_wr(1, 32'h0000_2001, 32'h0000_6008);
    fetch("pf root", 32'h0000_2010, 1'b1, 1'b1);
    fetch("ux user", 32'h0000_2010, 1'b1, 1'b0);

    // MSR port is read-first
    msr_imm_tlbh_idx = 4'd5;
    tick();
    old = mh[5];
    check("msr pre", msr_imm_tlbh, old);
    msr_imm_tlbh_nxt = 32'h1234_5678;
    msr_imm_tlbh_we  = 1'b1;
    tick();
    msr_imm_tlbh_we  = 1'b0;
    mh[5] = 32'h1234_5678;
    check("msr write cycle", msr_imm_tlbh, old);
    tick();
    check("msr after", msr_imm_tlbh, 32'h1234_5678);

    // Flush over a stalled command
    icache_cmd_ready = 1'b0;
    ibus_cmd_valid = 1'b1; ibus_cmd_addr = 32'h0000_3000; msr_psr_imme = 1'b0;
    tick();
    ibus_cmd_valid = 1'b0;
    check("stall cmd_ready", {31'b0, ibus_cmd_ready}, 32'd0);
    check("stall icache_cmd_valid", {31'b0, icache_cmd_valid}, 32'd1);
    ibus_flush_req = 1'b1;
    ibus_cmd_valid = 1'b1; ibus_cmd_addr = 32'h0000_0100;
    icache_valid = 1'b1; ibus_ready = 1'b1;
    #1;
    check("flush icache_cmd_valid", {31'b0, icache_cmd_valid}, 32'd0);
    check("flush cmd_ready", {31'b0, ibus_cmd_ready}, 32'd1);
    check("flush ack", {31'b0, ibus_flush_ack}, 32'd0);
    tick();
    ibus_flush_req = 1'b0; ibus_cmd_valid = 1'b0; icache_valid = 1'b0; ibus_ready = 1'b0;
    check("flush out_id", ibus_out_id, 32'h0000_0100);
    check("flush out_id_nxt", ibus_out_id_nxt, 32'h0000_0100);
    icache_cmd_ready = 1'b1;
    #1;
    check("redirect valid", {31'b0, icache_cmd_valid}, 32'd1);
    check("redirect addr", icache_cmd_addr, 32'h0000_0100);
    tick();
    check("redirect miss", {31'b0, exp_imm_tlb_miss}, 32'd0);

    // Randomised TLB programming and fetches against the model
    for (int it = 0; it < 60; it++) begin
      addr = $urandom;
      idx  = int'((addr / 8192) % Depth);
      if ($urandom_range(0, 3) != 0) begin
        l = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          l[31:13] = addr[31:13];
        end
        l[0] = ($urandom_range(0, 4) != 0);
        h = $urandom;
        msr_wr(idx, l, h);
      end
      msr_imm_tlbl_idx = N'(idx);
      tick();
      check("rnd tlbl rd", msr_imm_tlbl, ml[idx]);
      fetch("rnd", addr, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ncpu32k_immu.md
NCPU32K_IMMU -- requirements
Module: ncpu32k_immu

Interface
REQ-001 SHALL have parameter TLB_NSETS_LOG2, default 7, giving 2^TLB_NSETS_LOG2 TLB entries; legal range 1..19.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the reset-time instruction address.
REQ-003 SHALL use one clock and an asynchronous active-low reset:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- ibus_cmd_valid  in  1  fetch command valid.
- ibus_cmd_ready  out  1  fetch command accepted.
- ibus_cmd_addr  in  32  virtual fetch address.
- ibus_valid  out  1  instruction valid.
- ibus_ready  in  1  fetch unit accepts instruction.
- ibus_dout  out  32  instruction.
- ibus_flush_req  in  1  flush request.
- ibus_flush_ack  out  1  flush complete.
- ibus_out_id  out  32  PC of the instruction currently output.
- ibus_out_id_nxt  out  32  PC of the last accepted command.
- icache_cmd_valid  out  1  command to icache.
- icache_cmd_ready  in  1  icache accepts command.
- icache_cmd_addr  out  32  physical address.
- icache_valid  in  1  icache data valid.
- icache_ready  out  1  icache data accepted.
- icache_dout  in  32  icache data.
- exp_imm_tlb_miss  out  1  TLB miss exception.
- exp_imm_page_fault  out  1  page fault exception.
- msr_psr_imme  in  1  IMMU enable.
- msr_psr_rm  in  1  root (supervisor) mode.
- msr_immid  out  32  IMMU ID.
- msr_imm_tlbl  out  32  TLBL read data.
- msr_imm_tlbl_idx  in  TLB_NSETS_LOG2  TLBL index.
- msr_imm_tlbl_nxt  in  32  TLBL write data.
- msr_imm_tlbl_we  in  1  TLBL write enable.
- msr_imm_tlbh  out  32  TLBH read data.
- msr_imm_tlbh_idx  in  TLB_NSETS_LOG2  TLBH index.
- msr_imm_tlbh_nxt  in  32  TLBH write data.
- msr_imm_tlbh_we  in  1  TLBH write enable.

Function
REQ-005 SHALL hold a command-valid flag V: ibus_cmd_ready = ~V | icache_cmd_ready | flush_strobe; accept A = ibus_cmd_valid & ibus_cmd_ready; next V = A ? 1 : (V & ~(icache_cmd_ready | flush_strobe)).
REQ-006 SHALL define FS, which is reset to 0 and loads ibus_flush_req when V & icache_cmd_ready; flush_strobe = ibus_flush_req & ~FS.
REQ-007 SHALL drive icache_cmd_valid = V & ~flush_strobe and ibus_flush_ack = A & ~flush_strobe.
REQ-008 SHALL pass data combinationally: ibus_valid = icache_valid, icache_ready = ibus_ready, ibus_dout = icache_dout.
REQ-009 SHALL, on A, register msr_psr_imme, msr_psr_rm, addr[12:0] (offset), addr[31:13] (VPN) and the full addr (bypass address); all registers reset to 0.
REQ-010 SHALL set ibus_out_id_nxt to RESET_VECTOR-4 on reset and load ibus_cmd_addr on A.
REQ-011 SHALL set ibus_out_id to RESET_VECTOR on reset and, on ibus_valid & ibus_ready, load (ibus_flush_req ? ibus_cmd_addr : ibus_out_id_nxt).
REQ-012 SHALL drive msr_immid = {29'b0, TLB_NSETS_LOG2[2:0]}.
REQ-013 SHALL implement TLBL and TLBH as 2^N x 32 true-dual-port synchronous RAMs with every entry 0 after reset.
REQ-014 SHALL read TLB port A on A, at index ibus_cmd_addr[13+N-1:13], with registered output.
REQ-015 SHALL read TLB port B every cycle at msr_*_idx, with registered output msr_imm_tlbl/tlbh, writing msr_*_nxt when msr_*_we; port B is read-first (returns old data on a same-cycle write).
REQ-016 SHALL decode TLB fields as: V = L[0], VPN = L[31:13], UX = H[3], RX = H[4], PPN = H[31:13]; H[0] (P) and H[8] (S) are unused.
REQ-017 SHALL compute miss = imme_r & ~(V & VPN == vpn_r), denied = rm_r ? ~RX : ~UX, and pf = imme_r & denied & ~miss.
REQ-018 SHALL register exp_imm_tlb_miss and exp_imm_page_fault from miss and pf on icache_cmd_valid & icache_cmd_ready; both reset to 0 and are never high together.
REQ-019 SHALL drive icache_cmd_addr = imme_r ? {PPN, offset_r} : bypass address.

Reset
REQ-020 SHALL, while rst_n = 0: V = 0, FS = 0, icache_cmd_valid = 0, exceptions = 0, ibus_out_id = RESET_VECTOR, ibus_out_id_nxt = RESET_VECTOR-4, and TLB contents all zero.

Verification
REQ-021 SHALL cover: imme = 0, cmd 0x0000_2004 accepted, icache_cmd_ready = 1 -> next cycle icache_cmd_valid = 1, icache_cmd_addr = 0x0000_2004, no exception.
REQ-022 SHALL cover: TLBL[1] = 0x0000_2001, TLBH[1] = 0x0000_6018, imme = 1, rm = 1, cmd 0x0000_2010 -> icache_cmd_addr = 0x0000_6010; after icache handshake both exceptions = 0.
REQ-023 SHALL cover: the same setup with TLBL[1] = 0 -> exp_imm_tlb_miss = 1 and exp_imm_page_fault = 0 after the icache handshake.
REQ-024 SHALL cover: TLBH[1] = 0x0000_6008 (UX only), rm = 1 -> exp_imm_page_fault = 1 and exp_imm_tlb_miss = 0.
REQ-025 SHALL cover: pending command, icache_cmd_ready = 0, then ibus_flush_req with new cmd 0x100 -> icache_cmd_valid = 0 that cycle, the command is accepted, ibus_flush_ack = 0, and a data handshake loads ibus_out_id = 0x100.
REQ-026 SHALL cover: MSR write of TLBH[5] = 0x1234_5678 -> msr_imm_tlbh reads the old value in the write cycle and 0x1234_5678 one cycle later.
